switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Conditions a raw, bouncing board push-button into clean control signals
//  for the clock-generation stage. Sits directly upstream of the lazy PLL
//  block: dbc_pressPulse_o drives its frequency-switch input
//  (one 50 MHz cycle wide, one clean rising edge per accepted press).
//  Also provides a debounced level, a release pulse and a press-toggled level.
// PARAMETERS
//  ACTIVE_LOW      1         1: raw button reads 0 when pressed; 0: reads 1 when pressed
//  DEBOUNCE_CYCLES 500000    consecutive stable samples required (10 ms @ 50 MHz); legal >= 2
//  CNT_W           20        debounce counter width; 2**CNT_W > DEBOUNCE_CYCLES-1 (elab check)
// PORTS
//  dbc_clock50_i       in   1  system clock, 50 MHz
//  dbc_rstn_i          in   1  asynchronous, active-low reset
//  dbc_button_i        in   1  raw asynchronous button pin
//  dbc_level_o         out  1  debounced level, 1 = pressed
//  dbc_pressPulse_o    out  1  1-cycle pulse on each accepted press
//  dbc_releasePulse_o  out  1  1-cycle pulse on each accepted release
//  dbc_toggle_o        out  1  inverts on every accepted press
// BEHAVIOUR
//  Reset (async assert, sync use): all outputs 0, FSM = IDLE, counter = 0,
//   both sync flops = "released" value (1 if ACTIVE_LOW, else 0).
//  Input path: 2-flop synchronizer, then polarity fix -> p (1 = pressed).
//   FSM acts on p only; raw pin never used elsewhere.
//  FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. cnt counts stable samples.
//   IDLE:        p=1 -> PRESS_WAIT, cnt<=1; else stay, cnt<=0.
//   PRESS_WAIT:  p=0 -> IDLE, cnt<=0, no pulse (bounce rejected).
//                p=1 & cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt<=0,
//                  dbc_level_o<=1, dbc_pressPulse_o<=1, dbc_toggle_o<=~dbc_toggle_o.
//                p=1 otherwise -> cnt<=cnt+1.
//   HELD:        p=0 -> RELEASE_WAIT, cnt<=1; else stay.
//   RELEASE_WAIT: p=1 -> HELD, cnt<=0, no pulse.
//                p=0 & cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0,
//                  dbc_level_o<=0, dbc_releasePulse_o<=1.
//                p=0 otherwise -> cnt<=cnt+1.
//  Pulses: registered, high for exactly one cycle, then 0; never both high.
//  Latency: raw change sampled at edge E -> pulse/level updated at edge
//   E+1+DEBOUNCE_CYCLES (2 sync cycles overlap first count sample).
//  cnt never exceeds DEBOUNCE_CYCLES-1; no wrap possible.
//  Any single opposite sample during a WAIT state restarts debounce fully.
//  Reset mid-operation: outputs drop to 0 immediately (async); a button
//   still held at reset release yields a normal press pulse after debounce.
//  dbc_level_o changes only in the same cycle as its matching pulse.
// TESTING (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
//  1 Reset: rstn=0 with button=0 -> all outputs 0 within same cycle, held 0.
//  2 Clean press: button 1->0 sampled at edge 0, held -> pressPulse=1 only
//    for cycle after edge 5, level=1 and toggle=1 from edge 5.
//  3 Bounce: button low 2 cycles, high 1, then low steady -> no pulse until
//    4 consecutive pressed samples; exactly one pressPulse total.
//  4 Release: from HELD, button->1 steady -> releasePulse 1 cycle after 4
//    samples, level=0, toggle unchanged; 1-cycle release glitch -> no pulse.
//  5 Repeat: 3 clean press/release pairs -> 3 pressPulses, 3 releasePulses,
//    toggle ends at 1; pulses never overlap.
//  6 Reset mid-wait/held: assert rstn=0 in PRESS_WAIT and in HELD -> outputs 0
//    at once; release reset with button held -> pressPulse after 6 edges.

Source files
------------

// File: rtl/switch_debouncer.sv
// Debounces a raw push-button into a clean level, one-cycle press/release pulses and a press toggle.
// Latency: a raw change sampled at edge E updates the outputs at edge E+1+DEBOUNCE_CYCLES; no backpressure.
module switch_debouncer #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic dbc_clock50_i,
  input  logic dbc_rstn_i,
  input  logic dbc_button_i,
  output logic dbc_level_o,
  output logic dbc_pressPulse_o,
  output logic dbc_releasePulse_o,
  output logic dbc_toggle_o
);

  localparam logic             LP_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] LP_CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $error("switch_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end
    if ((CNT_W < 63) && ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES - 1))) begin : g_bad_cnt_w
      $error("switch_debouncer: CNT_W too narrow for DEBOUNCE_CYCLES-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_toggle;
  logic             w_pressed;

  // Synchronizer flops start at the idle pin level so reset release never looks like a press edge.
  always_ff @(posedge dbc_clock50_i or negedge dbc_rstn_i) begin
    if (!dbc_rstn_i) begin
      r_sync1 <= LP_RELEASED;
      r_sync2 <= LP_RELEASED;
    end else begin
      r_sync1 <= dbc_button_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ LP_RELEASED;

  always_ff @(posedge dbc_clock50_i or negedge dbc_rstn_i) begin
    if (!dbc_rstn_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pressed) begin
            r_state <= S_PRESS_WAIT;
            r_cnt   <= LP_CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!w_pressed) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_state  <= S_HELD;
            r_cnt    <= '0;
            r_level  <= 1'b1;
            r_press  <= 1'b1;
            r_toggle <= ~r_toggle;
          end else begin
            r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        S_HELD: begin
          if (!w_pressed) begin
            r_state <= S_RELEASE_WAIT;
            r_cnt   <= LP_CNT_ONE;
          end
        end
        S_RELEASE_WAIT: begin
          // A single pressed sample sends us back to HELD and the release count starts over.
          if (w_pressed) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign dbc_level_o        = r_level;
  assign dbc_pressPulse_o   = r_press;
  assign dbc_releasePulse_o = r_release;
  assign dbc_toggle_o       = r_toggle;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed-vector bench for switch_debouncer with DEBOUNCE_CYCLES=4, active-low button.
module tb_switch_debouncer;

  logic clk = 1'b0;
  logic rstn;
  logic button;
  logic level;
  logic press_p;
  logic rel_p;
  logic toggle;

  int total = 0;
  int bad   = 0;
  int press_cnt = 0;
  int rel_cnt   = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .dbc_clock50_i      (clk),
    .dbc_rstn_i         (rstn),
    .dbc_button_i       (button),
    .dbc_level_o        (level),
    .dbc_pressPulse_o   (press_p),
    .dbc_releasePulse_o (rel_p),
    .dbc_toggle_o       (toggle)
  );

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (press_p === 1'b1) press_cnt = press_cnt + 1;
      if (rel_p === 1'b1) rel_cnt = rel_cnt + 1;
      if (press_p === 1'b1 && rel_p === 1'b1) overlap_cnt = overlap_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, {31'd0, level}, 32'd0);
    chk({tag, "_press"}, {31'd0, press_p}, 32'd0);
    chk({tag, "_rel"}, {31'd0, rel_p}, 32'd0);
    chk({tag, "_toggle"}, {31'd0, toggle}, 32'd0);
  endtask

  int p0;
  int r0;

  initial begin
    rstn   = 1'b1;
    button = 1'b0;

    // 1: asynchronous reset with the button pressed
    #2 rstn = 1'b0;
    #1 chk_all_zero("rst_async");
    repeat (3) tick();
    chk_all_zero("rst_held");
    button = 1'b1;
    rstn   = 1'b1;
    repeat (4) tick();
    chk_all_zero("idle");

    // 2: clean press, change sampled at edge 0
    button = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk($sformatf("press_e%0d_pulse", e), {31'd0, press_p}, {31'd0, (e == 5)});
      chk($sformatf("press_e%0d_level", e), {31'd0, level}, {31'd0, (e >= 5)});
      chk($sformatf("press_e%0d_toggle", e), {31'd0, toggle}, {31'd0, (e >= 5)});
    end
    repeat (3) tick();

    // 4a: one-cycle release glitch while held
    r0 = rel_cnt;
    button = 1'b1;
    tick();
    button = 1'b0;
    repeat (10) tick();
    chk("glitch_relcnt", rel_cnt - r0, 0);
    chk("glitch_level", {31'd0, level}, 32'd1);

    // 4b: steady release
    button = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk($sformatf("rel_e%0d_pulse", e), {31'd0, rel_p}, {31'd0, (e == 5)});
      chk($sformatf("rel_e%0d_level", e), {31'd0, level}, {31'd0, (e < 5)});
      chk($sformatf("rel_e%0d_toggle", e), {31'd0, toggle}, 32'd1);
    end
    repeat (3) tick();

    // 3: bounce low,low,high then low steady: last change at edge 3 -> pulse at edge 8
    p0 = press_cnt;
    for (int e = 0; e <= 10; e++) begin
      button = (e == 2) ? 1'b1 : 1'b0;
      tick();
      chk($sformatf("bnc_e%0d_pulse", e), {31'd0, press_p}, {31'd0, (e == 8)});
      chk($sformatf("bnc_e%0d_level", e), {31'd0, level}, {31'd0, (e >= 8)});
      chk($sformatf("bnc_e%0d_toggle", e), {31'd0, toggle}, {31'd0, (e < 8)});
    end
    chk("bnc_presscnt", press_cnt - p0, 1);
    button = 1'b1;
    repeat (8) tick();
    chk("bnc_rel_level", {31'd0, level}, 32'd0);

    // 5: three clean press/release pairs
    p0 = press_cnt;
    r0 = rel_cnt;
    for (int k = 0; k < 3; k++) begin
      button = 1'b0;
      repeat (7) tick();
      button = 1'b1;
      repeat (7) tick();
    end
    chk("rep_presscnt", press_cnt - p0, 3);
    chk("rep_relcnt", rel_cnt - r0, 3);
    chk("rep_toggle", {31'd0, toggle}, 32'd1);
    chk("rep_level", {31'd0, level}, 32'd0);

    // 6a: reset during PRESS_WAIT drops toggle at once
    button = 1'b0;
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1 chk_all_zero("rst_pw");
    repeat (2) tick();
    rstn = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk($sformatf("rstrel_e%0d_pulse", e), {31'd0, press_p}, {31'd0, (e == 5)});
      chk($sformatf("rstrel_e%0d_level", e), {31'd0, level}, {31'd0, (e >= 5)});
    end
    chk("rstrel_toggle", {31'd0, toggle}, 32'd1);

    // 6b: reset while HELD
    #2 rstn = 1'b0;
    #1 chk_all_zero("rst_held_state");
    button = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (8) tick();
    chk_all_zero("post_rst_idle");

    chk("overlap", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
